fib_ctrl: RTL and testbench

FIB_CTRL -- requirements
Module: fib_ctrl

---
 rtl/fib_ctrl.sv | 149 ++++++++++++++
 tb/tb_fib_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_ctrl.sv
// Start-button front end and request/response controller for a Fibonacci datapath:
// synchronise and debounce the button, hand the operand over, capture the result or time out.
module fib_ctrl #(
  parameter int DB_COUNT = 1000000,
  parameter int TIMEOUT  = 65535,
  parameter int N_W      = 5,
  parameter int R_W      = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           btn,
  input  logic [N_W-1:0] sw,
  input  logic           dp_ready,
  input  logic           dp_done,
  input  logic [R_W-1:0] dp_result,
  output logic           dp_start,
  output logic [N_W-1:0] dp_n,
  output logic [R_W-1:0] result,
  output logic           result_valid,
  output logic           busy,
  output logic           err
);

  localparam int DB_W = $clog2(DB_COUNT + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_COUNT - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  function automatic logic [DB_W-1:0] db_sat_inc(input logic [DB_W-1:0] v);
    return (v == {DB_W{1'b1}}) ? v : v + DB_W'(1);
  endfunction

  function automatic logic [TO_W-1:0] to_sat_inc(input logic [TO_W-1:0] v);
    return (v == {TO_W{1'b1}}) ? v : v + TO_W'(1);
  endfunction

  logic [1:0]      sync_q;
  logic            db_level_q, db_level_d;
  logic            db_prev_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            tick_q, tick_d;

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [N_W-1:0]  dp_n_q, dp_n_d;
  logic [R_W-1:0]  result_q, result_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  // Debounce: the filtered level flips on the DB_COUNT-th consecutive differing cycle.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    if (sync_q[1] != db_level_q) begin
      if (db_cnt_q >= DB_LAST) begin
        db_level_d = ~db_level_q;
      end else begin
        db_cnt_d = db_sat_inc(db_cnt_q);
      end
    end
  end

  // Rising edge of the filtered level only; releases never start a request.
  assign tick_d = db_level_q & ~db_prev_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    dp_n_d     = dp_n_q;
    result_d   = result_q;
    valid_d    = valid_q;
    err_d      = err_q;
    dp_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick_q) begin
          dp_n_d  = sw;
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        dp_start = dp_ready;
        if (dp_ready) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        wait_cnt_d = to_sat_inc(wait_cnt_q);
        // A completion arriving on the last allowed cycle still counts as success.
        if (dp_done) begin
          result_d = dp_result;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end else if (wait_cnt_q >= TO_LAST) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= 2'b00;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
      tick_q     <= 1'b0;
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      dp_n_q     <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn};
      db_level_q <= db_level_d;
      db_prev_q  <= db_level_q;
      db_cnt_q   <= db_cnt_d;
      tick_q     <= tick_d;
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      dp_n_q     <= dp_n_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign dp_n         = dp_n_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign err          = err_q;
  assign busy         = (state_q == S_REQ) || (state_q == S_WAIT);

endmodule

// File: tb/tb_fib_ctrl.sv
// Directed bench for fib_ctrl with DB_COUNT=4, TIMEOUT=8: a table of full transactions
// plus scripted sequences for bounce, stall, busy press and reset corner cases.
module tb_fib_ctrl;

  logic        clk;
  logic        reset;
  logic        btn;
  logic [4:0]  sw;
  logic        dp_ready;
  logic        dp_done;
  logic [19:0] dp_result;
  logic        dp_start;
  logic [4:0]  dp_n;
  logic [19:0] result;
  logic        result_valid;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  fib_ctrl #(
    .DB_COUNT(4),
    .TIMEOUT (8),
    .N_W     (5),
    .R_W     (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .sw          (sw),
    .dp_ready    (dp_ready),
    .dp_done     (dp_done),
    .dp_result   (dp_result),
    .dp_start    (dp_start),
    .dp_n        (dp_n),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  n;
    logic [19:0] res;
    int          dly;      // WAIT cycle carrying dp_done (1..8), 0 = never
    logic [19:0] exp_res;
    logic        exp_rv;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Button has just risen (or reset released with it high): tick after 7 edges, REQ after 8.
  task automatic expect_tick(input logic [4:0] n);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("pre_tick_busy", 32'(busy), 32'(0));
      chk("pre_tick_start", 32'(dp_start), 32'(0));
    end
    step();
    chk("press_busy", 32'(busy), 32'(1));
    chk("press_dp_n", 32'(dp_n), 32'(n));
    chk("press_err_clr", 32'(err), 32'(0));
    chk("press_rv_clr", 32'(result_valid), 32'(0));
  endtask

  task automatic press(input logic [4:0] n);
    sw  = n;
    btn = 1'b1;
    expect_tick(n);
  endtask

  // Called in a REQ cycle with dp_ready=1; returns in the first cycle back in IDLE.
  task automatic finish_txn(input int d, input logic [19:0] res);
    chk("req_start", 32'(dp_start), 32'(1));
    step();
    for (int w = 1; w <= 8; w++) begin
      chk("wait_busy", 32'(busy), 32'(1));
      chk("wait_start", 32'(dp_start), 32'(0));
      if (w == d) begin
        dp_done   = 1'b1;
        dp_result = res;
      end
      step();
      dp_done   = 1'b0;
      dp_result = 20'h0BAD0;
      if (w == d) break;
    end
  endtask

  task automatic release_btn();
    btn = 1'b0;
    repeat (10) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected bench end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int starts;
    vecs[0] = '{5'd10, 20'd55,      3, 20'd55,      1'b1, 1'b0};
    vecs[1] = '{5'd7,  20'd13,      1, 20'd13,      1'b1, 1'b0};
    vecs[2] = '{5'd0,  20'd999,     0, 20'd13,      1'b0, 1'b1};
    vecs[3] = '{5'd20, 20'd6765,    8, 20'd6765,    1'b1, 1'b0};
    vecs[4] = '{5'd31, 20'hFFFFF,   2, 20'hFFFFF,   1'b1, 1'b0};
    vecs[5] = '{5'd5,  20'd5,       0, 20'hFFFFF,   1'b0, 1'b1};

    reset     = 1'b1;
    btn       = 1'b0;
    sw        = 5'd0;
    dp_ready  = 1'b1;
    dp_done   = 1'b0;
    dp_result = 20'h0BAD0;
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_start", 32'(dp_start), 32'(0));
    chk("rst_dp_n", 32'(dp_n), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_rv", 32'(result_valid), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    repeat (3) step();
    reset = 1'b0;
    repeat (10) step();
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_result", 32'(result), 32'(0));

    for (int i = 0; i < 6; i++) begin
      press(vecs[i].n);
      finish_txn(vecs[i].dly, vecs[i].res);
      chk("done_busy", 32'(busy), 32'(0));
      chk("done_result", 32'(result), 32'(vecs[i].exp_res));
      chk("done_rv", 32'(result_valid), 32'(vecs[i].exp_rv));
      chk("done_err", 32'(err), 32'(vecs[i].exp_err));
      chk("done_dp_n", 32'(dp_n), 32'(vecs[i].n));
      release_btn();
    end

    // Bounce: 2 high / 2 low for 20 cycles, then a clean hold.
    for (int c = 0; c < 20; c++) begin
      btn = ((c / 2) % 2 == 0);
      step();
      chk("bounce_busy", 32'(busy), 32'(0));
      chk("bounce_start", 32'(dp_start), 32'(0));
    end
    press(5'd3);
    finish_txn(3, 20'd2);
    chk("bounce_result", 32'(result), 32'(2));
    chk("bounce_rv", 32'(result_valid), 32'(1));
    release_btn();

    // Stall in REQ for 5 cycles; a stray dp_done there must be ignored.
    dp_ready = 1'b0;
    press(5'd11);
    for (int i = 0; i < 5; i++) begin
      chk("stall_start", 32'(dp_start), 32'(0));
      chk("stall_busy", 32'(busy), 32'(1));
      chk("stall_rv", 32'(result_valid), 32'(0));
      if (i == 2) begin
        dp_done   = 1'b1;
        dp_result = 20'd777;
      end
      step();
      dp_done   = 1'b0;
      dp_result = 20'h0BAD0;
    end
    dp_ready = 1'b1;
    #1;
    finish_txn(2, 20'd89);
    chk("stall_result", 32'(result), 32'(89));
    chk("stall_err", 32'(err), 32'(0));
    release_btn();

    // Second debounced press lands in WAIT: dropped, dp_n kept.
    starts = 0;
    for (int t = 0; t < 45; t++) begin
      btn       = (t < 4) || (t >= 10 && t < 30);
      dp_ready  = (t >= 11);
      dp_done   = (t == 18);
      dp_result = (t == 18) ? 20'd144 : 20'h0BAD0;
      sw        = (t < 8) ? 5'd9 : 5'd17;
      #1;
      if (dp_start) starts++;
      chk("bp_busy", 32'(busy), 32'((t >= 8) && (t <= 18)));
      if (t >= 8) chk("bp_dp_n", 32'(dp_n), 32'(9));
      if (t == 11) chk("bp_start_cycle", 32'(dp_start), 32'(1));
      step();
    end
    dp_done = 1'b0;
    chk("bp_start_count", 32'(starts), 32'(1));
    chk("bp_result", 32'(result), 32'(144));
    chk("bp_rv", 32'(result_valid), 32'(1));

    // Reset in WAIT with dp_done pending, button held through release.
    dp_ready = 1'b1;
    press(5'd12);
    step();
    step();
    reset     = 1'b1;
    dp_done   = 1'b1;
    dp_result = 20'd4242;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_result", 32'(result), 32'(0));
    chk("mid_rst_rv", 32'(result_valid), 32'(0));
    chk("mid_rst_dp_n", 32'(dp_n), 32'(0));
    chk("mid_rst_start", 32'(dp_start), 32'(0));
    step();
    dp_done   = 1'b0;
    dp_result = 20'h0BAD0;
    reset     = 1'b0;
    chk("post_rst_result", 32'(result), 32'(0));
    expect_tick(5'd12);
    finish_txn(1, 20'd21);
    chk("held_result", 32'(result), 32'(21));
    chk("held_rv", 32'(result_valid), 32'(1));
    for (int i = 0; i < 20; i++) begin
      step();
      chk("held_no_retick", 32'(busy), 32'(0));
    end
    release_btn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
